// File: rtl/cpu_fwd_pkg.sv
// Shared types and constants for the execute-stage operand bypass network.
//   tag_t        : destination/source register tag (GPRs 1..31 plus HI/LO/HILO)
//   sb_entry_t   : one in-flight scoreboard entry {valid, tag, is_load}
//   src_b_mode_e : ALU operand B source select
//   tag_hit()    : tag comparison including the HILO wildcard
package cpu_fwd_pkg;

    localparam int TAG_W = 6;
    typedef logic [TAG_W-1:0] tag_t;

    localparam tag_t TAG_ZERO = 6'd0;
    localparam tag_t TAG_HI   = 6'd32;
    localparam tag_t TAG_LO   = 6'd33;
    localparam tag_t TAG_HILO = 6'd34;
    localparam tag_t TAG_NONE = 6'd63;

    localparam int NUM_STAGES_DEFAULT = 3;
    localparam int SEL_W = $clog2(NUM_STAGES_DEFAULT + 1);

    typedef struct packed {
        logic valid;
        tag_t tag;
        logic is_load;
    } sb_entry_t;

    typedef enum logic [1:0] {
        SRC_B_FWD  = 2'b00,
        SRC_B_IMM  = 2'b01,
        SRC_B_PC8  = 2'b10,
        SRC_B_ZERO = 2'b11
    } src_b_mode_e;

    function automatic int sel_width(int num_stages);
        return $clog2(num_stages + 1);
    endfunction

    // $0 and "no register" never forward. A MULT tracked as HILO satisfies
    // a read of either half; the stage data already carries the right half.
    function automatic logic tag_hit(tag_t entry_tag, tag_t src);
        logic hit;
        hit = 1'b0;
        if (src != TAG_ZERO && src != TAG_NONE) begin
            hit = (entry_tag == src) ||
                  (entry_tag == TAG_HILO && (src == TAG_HI || src == TAG_LO));
        end
        return hit;
    endfunction

endpackage

// File: rtl/operand_bypass_network_fwd_select.sv
// Per-operand priority matcher over the in-flight scoreboard.
//   sb          : scoreboard entries, index 0 = youngest (memory stage)
//   src_tag     : source tag being resolved
//   reg_data    : register-file read data for this source
//   stage_data  : result data held in each tracked stage
//   sel         : 0 = regfile, s+1 = stage s
//   not_ready   : youngest match is a load not yet at the ready stage
//   data        : resolved operand value (don't-care while not_ready)
module fwd_select
    import cpu_fwd_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_STAGES  = 3,
    parameter int READY_STAGE = 1,
    parameter int SW          = 2
) (
    input  sb_entry_t [NUM_STAGES-1:0]        sb,
    input  tag_t                              src_tag,
    input  logic      [DATA_W-1:0]            reg_data,
    input  logic      [NUM_STAGES*DATA_W-1:0] stage_data,
    output logic      [SW-1:0]                sel,
    output logic                              not_ready,
    output logic      [DATA_W-1:0]            data
);

    // Scan oldest to youngest so the youngest match is the last to write,
    // which also keeps an older ready result from masking a pending load.
    always_comb begin
        sel       = '0;
        not_ready = 1'b0;
        data      = reg_data;
        for (int s = NUM_STAGES - 1; s >= 0; s--) begin
            if (sb[s].valid && tag_hit(sb[s].tag, src_tag)) begin
                sel       = SW'(s + 1);
                not_ready = sb[s].is_load && (s < READY_STAGE);
                data      = stage_data[s*DATA_W +: DATA_W];
            end
        end
        if (src_tag == TAG_ZERO) begin
            data = '0;
        end
    end

endmodule

// File: rtl/operand_bypass_network.sv
// Execute-stage operand bypass with an internal in-flight destination
// scoreboard. Resolves each source operand to the youngest ready producer
// and raises a load-use stall when that producer is not yet data-ready.
//   clk, reset_n           : clock, async active-low reset
//   issue_*                : execute-stage instruction being tracked
//   flush                  : kill execute and all tracked stages
//   src_tag, src_reg_data  : per-source tags and regfile read data
//   stage_data             : result data in each tracked stage
//   src_b_mode, sign_imm,
//   pc_plus_8              : ALU operand B selection inputs
//   src_a, src_b,
//   write_data             : resolved ALU operands and store data
//   fwd_sel                : per-source bypass select (0 = regfile)
//   stall                  : hold front end, bubble into the scoreboard
module operand_bypass_network
    import cpu_fwd_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_SRC     = 2,
    parameter int NUM_STAGES  = 3,
    parameter int READY_STAGE = 1,
    localparam int LSEL_W     = sel_width(NUM_STAGES)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          issue_valid,
    input  logic [TAG_W-1:0]              issue_dst,
    input  logic                          issue_is_load,
    input  logic                          flush,
    input  logic [NUM_SRC*TAG_W-1:0]      src_tag,
    input  logic [NUM_SRC*DATA_W-1:0]     src_reg_data,
    input  logic [NUM_STAGES*DATA_W-1:0]  stage_data,
    input  logic [1:0]                    src_b_mode,
    input  logic [DATA_W-1:0]             sign_imm,
    input  logic [DATA_W-1:0]             pc_plus_8,
    output logic [DATA_W-1:0]             src_a,
    output logic [DATA_W-1:0]             src_b,
    output logic [DATA_W-1:0]             write_data,
    output logic [NUM_SRC*LSEL_W-1:0]     fwd_sel,
    output logic                          stall
);

    sb_entry_t [NUM_STAGES-1:0] sb_q, sb_d;
    logic      [NUM_SRC-1:0]    not_ready;
    logic      [DATA_W-1:0]     opnd [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_select #(
            .DATA_W      (DATA_W),
            .NUM_STAGES  (NUM_STAGES),
            .READY_STAGE (READY_STAGE),
            .SW          (LSEL_W)
        ) u_fwd_select (
            .sb         (sb_q),
            .src_tag    (src_tag[i*TAG_W +: TAG_W]),
            .reg_data   (src_reg_data[i*DATA_W +: DATA_W]),
            .stage_data (stage_data),
            .sel        (fwd_sel[i*LSEL_W +: LSEL_W]),
            .not_ready  (not_ready[i]),
            .data       (opnd[i])
        );
    end

    assign stall = issue_valid & (|not_ready);

    // A stalled execute instruction enters as a bubble; older entries keep
    // draining so the pending load can reach the ready stage.
    always_comb begin
        sb_d = '0;
        if (!flush) begin
            sb_d[0].valid   = issue_valid & ~stall;
            sb_d[0].tag     = issue_dst;
            sb_d[0].is_load = issue_is_load;
            for (int s = 1; s < NUM_STAGES; s++) begin
                sb_d[s] = sb_q[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign src_a      = opnd[0];
    assign write_data = opnd[1];

    always_comb begin
        src_b = opnd[1];
        case (src_b_mode_e'(src_b_mode))
            SRC_B_FWD:  src_b = opnd[1];
            SRC_B_IMM:  src_b = sign_imm;
            SRC_B_PC8:  src_b = pc_plus_8;
            SRC_B_ZERO: src_b = '0;
            default:    src_b = opnd[1];
        endcase
    end

endmodule

// File: tb/tb_operand_bypass_network.sv
`timescale 1ns/1ps
module tb_operand_bypass_network;
    import cpu_fwd_pkg::*;

    localparam logic [31:0] R0  = 32'hA0A0_0000;
    localparam logic [31:0] R1  = 32'hB1B1_0001;
    localparam logic [31:0] IMM = 32'h0000_0FF0;
    localparam logic [31:0] PC8 = 32'h0000_4008;

    logic        clk;
    logic        reset_n;
    logic        issue_valid;
    logic [5:0]  issue_dst;
    logic        issue_is_load;
    logic        flush;
    logic [11:0] src_tag;
    logic [63:0] src_reg_data;
    logic [95:0] stage_data;
    logic [1:0]  src_b_mode;
    logic [31:0] sign_imm;
    logic [31:0] pc_plus_8;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] write_data;
    logic [3:0]  fwd_sel;
    logic        stall;

    operand_bypass_network #(
        .DATA_W(32), .NUM_SRC(2), .NUM_STAGES(3), .READY_STAGE(1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .issue_valid   (issue_valid),
        .issue_dst     (issue_dst),
        .issue_is_load (issue_is_load),
        .flush         (flush),
        .src_tag       (src_tag),
        .src_reg_data  (src_reg_data),
        .stage_data    (stage_data),
        .src_b_mode    (src_b_mode),
        .sign_imm      (sign_imm),
        .pc_plus_8     (pc_plus_8),
        .src_a         (src_a),
        .src_b         (src_b),
        .write_data    (write_data),
        .fwd_sel       (fwd_sel),
        .stall         (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] wd;
        logic [3:0]  sel;
        logic        st;
        bit          ca;
        bit          cb;
        bit          csel;
    } exp_t;

    exp_t q[$];
    int   passes = 0;
    int   total  = 0;

    task automatic idle();
        issue_valid   = 1'b0;
        issue_dst     = TAG_NONE;
        issue_is_load = 1'b0;
        flush         = 1'b0;
        src_tag       = {TAG_NONE, TAG_NONE};
        src_reg_data  = {R1, R0};
        stage_data    = {32'h3000_0003, 32'h2000_0002, 32'h1000_0001};
        src_b_mode    = 2'b00;
        sign_imm      = IMM;
        pc_plus_8     = PC8;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] wd, input logic [3:0] sel,
                        input logic st, input bit ca, input bit cb, input bit csel);
        exp_t e;
        e.a = a; e.b = b; e.wd = wd; e.sel = sel; e.st = st;
        e.ca = ca; e.cb = cb; e.csel = csel;
        q.push_back(e);
    endtask

    task automatic push_rf();
        push(R0, R1, R1, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic chk(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            total++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = q.pop_front();
            total++;
            assert (stall === e.st) passes++;
            else $error("FAIL %s stall got %b exp %b", tag, stall, e.st);
            if (e.ca) begin
                total++;
                assert (src_a === e.a) passes++;
                else $error("FAIL %s src_a got %h exp %h", tag, src_a, e.a);
            end
            if (e.cb) begin
                total++;
                assert (src_b === e.b) passes++;
                else $error("FAIL %s src_b got %h exp %h", tag, src_b, e.b);
                total++;
                assert (write_data === e.wd) passes++;
                else $error("FAIL %s write_data got %h exp %h", tag, write_data, e.wd);
            end
            if (e.csel) begin
                total++;
                assert (fwd_sel === e.sel) passes++;
                else $error("FAIL %s fwd_sel got %b exp %b", tag, fwd_sel, e.sel);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        #1 push_rf(); chk("reset");
        @(negedge clk); reset_n = 1'b1;

        // back-to-back ALU forward from stage 0
        @(negedge clk); idle(); issue_valid = 1'b1; issue_dst = 6'd3;
        #1 push_rf(); chk("b2b_issue");
        @(negedge clk); idle(); src_tag[5:0] = 6'd3; stage_data[31:0] = 32'hDEAD_BEEF;
        #1 push(32'hDEAD_BEEF, R1, R1, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b1); chk("b2b_fwd");

        // youngest of two producers wins
        @(negedge clk); idle(); issue_valid = 1'b1; issue_dst = 6'd4;
        @(negedge clk); idle(); issue_valid = 1'b1; issue_dst = 6'd4;
        @(negedge clk); idle(); src_tag[5:0] = 6'd4;
        stage_data[31:0] = 32'h11; stage_data[63:32] = 32'h22;
        #1 push(32'h11, R1, R1, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b1); chk("youngest");

        // load-use stall, then forward from stage 1; stalled r8 must be a bubble
        @(negedge clk); idle(); issue_valid = 1'b1; issue_dst = 6'd7; issue_is_load = 1'b1;
        @(negedge clk); idle(); issue_valid = 1'b1; issue_dst = 6'd8; src_tag[11:6] = 6'd7;
        #1 push(R0, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0); chk("load_use_stall");
        @(negedge clk); idle(); src_tag = {6'd7, 6'd8}; stage_data[63:32] = 32'h7777_0001;
        #1 push(R0, 32'h7777_0001, 32'h7777_0001, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("load_ready");

        // $0 reads zero even with a valid tag-0 entry; flush kills r9
        @(negedge clk); idle(); issue_valid = 1'b1; issue_dst = TAG_ZERO;
        @(negedge clk); idle(); issue_valid = 1'b1; issue_dst = 6'd9;
        src_tag[5:0] = TAG_ZERO; src_reg_data[31:0] = 32'hFFFF_FFFF;
        #1 push(32'h0, R1, R1, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1); chk("zero_reg");
        @(negedge clk); idle(); flush = 1'b1; issue_valid = 1'b1; issue_dst = 6'd10;
        src_tag[5:0] = 6'd9; stage_data[31:0] = 32'h0000_9999;
        #1 push(32'h0000_9999, R1, R1, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b1); chk("pre_flush");
        @(negedge clk); idle(); src_tag = {6'd10, 6'd9};
        #1 push_rf(); chk("post_flush");

        // HILO producer, src_b modes
        @(negedge clk); idle(); issue_valid = 1'b1; issue_dst = TAG_HILO;
        @(negedge clk); idle(); src_tag[5:0] = TAG_LO; stage_data[31:0] = 32'h5555_AAAA;
        src_b_mode = 2'b10;
        #1 push(32'h5555_AAAA, PC8, R1, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b1); chk("hilo_pc8");
        src_b_mode = 2'b11;
        #1 push(32'h5555_AAAA, 32'h0, R1, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b1); chk("mode_zero");
        src_b_mode = 2'b01;
        #1 push(32'h5555_AAAA, IMM, R1, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b1); chk("mode_imm");
        src_b_mode = 2'b00; src_tag[11:6] = TAG_HI;
        #1 push(32'h5555_AAAA, 32'h5555_AAAA, 32'h5555_AAAA, 4'b0101, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("hilo_hi");

        // stall gating by issue_valid, then reset mid-stream
        @(negedge clk); idle(); issue_valid = 1'b1; issue_dst = 6'd5; issue_is_load = 1'b1;
        @(negedge clk); idle(); src_tag[5:0] = 6'd5;
        #1 push(R0, R1, R1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0); chk("stall_gated");
        issue_valid = 1'b1;
        #1 push(R0, R1, R1, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0); chk("stall_pending");
        reset_n = 1'b0;
        #1 push_rf(); chk("reset_mid");
        issue_valid = 1'b0; reset_n = 1'b1;
        @(negedge clk); idle(); issue_valid = 1'b1; src_tag[5:0] = 6'd5;
        #1 push_rf(); chk("post_reset_r5");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
